iosf_cfg_sc_fifo: RTL and testbench

- Parametrised single-clock FIFO for the IOSF-to-config datapath, for paths where the CDC is already resolved upstream.
- Successor to the fixed 144-bit dual-clock config FIFO. Generalises width and depth, and adds:
  - a show-ahead/normal read mode,
  - occupancy count and programmable almost-full/almost-empty flags,
  - synchronous clear,
  - sticky overflow/underflow error flags.
- Sits between the IOSF sideband receive logic and the config-space register block.

---
 rtl/iosf_cfg_fifo_pkg.sv | 24 ++
 rtl/iosf_cfg_fifo_ram.sv | 43 ++++
 rtl/iosf_cfg_sc_fifo.sv | 156 +++++++++++++++
 tb/tb_iosf_cfg_sc_fifo.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/iosf_cfg_fifo_pkg.sv
// Shared helpers for the IOSF config single-clock FIFO.
// Sizing functions, default count type, parity (IOSF_CFG_SC_FIFO_PARITY_EN).
package iosf_cfg_fifo_pkg;

  localparam int unsigned PAR_MAX_W = 1024;
  localparam int unsigned DEF_DEPTH = 16;
  localparam int unsigned DEF_CNT_W = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_CNT_W-1:0] cnt_t;

  function automatic int unsigned addr_w(input int unsigned depth);
    return $clog2(depth);
  endfunction

  function automatic int unsigned cnt_w(input int unsigned depth);
    return $clog2(depth) + 1;
  endfunction

  // Zero padding leaves the XOR reduction unchanged.
  function automatic logic even_par(input logic [PAR_MAX_W-1:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/iosf_cfg_fifo_ram.sv
// Simple dual-port RAM, one write and one registered read port on clk.
// Read port forwards same-cycle write data so look-ahead reads see it.
module iosf_cfg_fifo_ram
  import iosf_cfg_fifo_pkg::*;
#(
  parameter int unsigned W  = 145,
  parameter int unsigned D  = 16,
  parameter int unsigned AW = addr_w(D)
) (
  input  logic          clk,
  input  logic          aclr,
  input  logic          sclr,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [W-1:0]  wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [W-1:0]  rdata_o
);

  logic [W-1:0] mem_q [D];
  logic [W-1:0] rdata_q;

  // Storage array, no reset: contents are discarded via the pointers.
  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Registered read with write-to-read forwarding.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      rdata_q <= '0;
    end else if (sclr) begin
      rdata_q <= '0;
    end else if (re_i) begin
      rdata_q <= (we_i && (waddr_i == raddr_i)) ? wdata_i
                                                : mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/iosf_cfg_sc_fifo.sv
// Single-clock FIFO between IOSF sideband RX and config registers.
// Optional per-entry parity via IOSF_CFG_SC_FIFO_PARITY_EN.
module iosf_cfg_sc_fifo
  import iosf_cfg_fifo_pkg::*;
#(
  parameter int unsigned WIDTH         = 144,
  parameter int unsigned DEPTH         = 16,
  parameter int unsigned SHOWAHEAD     = 1,
  parameter int unsigned AFULL_THRESH  = DEPTH - 2,
  parameter int unsigned AEMPTY_THRESH = 1
) (
  input  logic                       clk,
  input  logic                       aclr,
  input  logic                       sclr,
  input  logic [WIDTH-1:0]           data,
  input  logic                       wrreq,
  input  logic                       rdreq,
  input  logic                       clr_err,
  output logic [WIDTH-1:0]           q,
  output logic                       rdempty,
  output logic                       wrfull,
  output logic                       almost_full,
  output logic                       almost_empty,
  output logic [$clog2(DEPTH):0]     usedw,
  output logic                       overflow,
  output logic                       underflow
`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
  ,
  output logic                       parity_err
`endif
);

  localparam int unsigned AW = addr_w(DEPTH);
  localparam int unsigned CW = cnt_w(DEPTH);
`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
  localparam int unsigned MW = WIDTH + 1;
`else
  localparam int unsigned MW = WIDTH;
`endif

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] rd_ptr_nxt;
  logic [CW-1:0] usedw_q, usedw_d, cnt_nxt;
  logic          empty_q, empty_d;
  logic          full_q, full_d;
  logic          afull_q, afull_d;
  logic          aempty_q, aempty_d;
  logic          ovf_q, ovf_d;
  logic          unf_q, unf_d;
  logic          wr_acc, rd_acc;
  logic          ram_re;
  logic [AW-1:0] ram_raddr;
  logic [MW-1:0] ram_wdata, ram_rdata;

  // Accept decisions, next pointers/count, flags and RAM read control.
  always_comb begin
    wr_acc     = wrreq && !full_q;
    rd_acc     = rdreq && !empty_q;
    rd_ptr_nxt = rd_ptr_q + AW'(rd_acc);
    cnt_nxt    = usedw_q + CW'(wr_acc) - CW'(rd_acc);
    wr_ptr_d   = wr_ptr_q + AW'(wr_acc);
    rd_ptr_d   = rd_ptr_nxt;
    usedw_d    = cnt_nxt;
    ovf_d      = (wrreq && full_q) || (ovf_q && !clr_err);
    unf_d      = (rdreq && empty_q) || (unf_q && !clr_err);
    if (sclr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      usedw_d  = '0;
      ovf_d    = 1'b0;
      unf_d    = 1'b0;
    end
    empty_d  = (usedw_d == '0);
    full_d   = (usedw_d == CW'(DEPTH));
    afull_d  = (usedw_d >= CW'(AFULL_THRESH));
    aempty_d = (usedw_d <= CW'(AEMPTY_THRESH));
    // Show-ahead reloads q only when the head changes.
    if (SHOWAHEAD != 0) begin
      ram_re    = (rd_acc || empty_q) && (cnt_nxt != '0);
      ram_raddr = rd_ptr_nxt;
    end else begin
      ram_re    = rd_acc;
      ram_raddr = rd_ptr_q;
    end
  end

  // Control state: pointers, count, registered flags, sticky errors.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      usedw_q  <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      usedw_q  <= usedw_d;
      empty_q  <= empty_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
      aempty_q <= aempty_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
    end
  end

`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
  logic wr_par;
  logic chk_q;

  assign wr_par    = even_par(PAR_MAX_W'(data));
  assign ram_wdata = {wr_par, data};

  // Marks the cycle a freshly loaded word sits on q.
  always_ff @(posedge clk or posedge aclr) begin
    if (aclr) chk_q <= 1'b0;
    else      chk_q <= ram_re && !sclr;
  end

  assign parity_err = chk_q && (^ram_rdata);
`else
  assign ram_wdata = data;
`endif

  iosf_cfg_fifo_ram #(
    .W  (MW),
    .D  (DEPTH),
    .AW (AW)
  ) u_ram (
    .clk     (clk),
    .aclr    (aclr),
    .sclr    (sclr),
    .we_i    (wr_acc),
    .waddr_i (wr_ptr_q),
    .wdata_i (ram_wdata),
    .re_i    (ram_re),
    .raddr_i (ram_raddr),
    .rdata_o (ram_rdata)
  );

  assign q            = ram_rdata[WIDTH-1:0];
  assign rdempty      = empty_q;
  assign wrfull       = full_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign usedw        = usedw_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_iosf_cfg_sc_fifo.sv
// Directed bench for iosf_cfg_sc_fifo: show-ahead 144x16 plus a
// normal-mode 8x4 instance for read-latency checks.
module tb_iosf_cfg_sc_fifo;

  logic         clk = 1'b0;
  logic         aclr, sclr, wrreq, rdreq, clr_err;
  logic [143:0] data;
  logic [143:0] q;
  logic         rdempty, wrfull, almost_full, almost_empty;
  logic [4:0]   usedw;
  logic         overflow, underflow;

  logic         wr0, rd0, clr0;
  logic [7:0]   d0, q0;
  logic         rdempty0, wrfull0, afull0, aempty0, ovf0, unf0;
  logic [2:0]   usedw0;

`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
  logic         parity_err, parity_err0;
`endif

  int           total = 0;
  int           passed = 0;
  int           fails = 0;
  int           cnt = 0;
  logic [143:0] sb [$];

  always #5 clk = ~clk;

  iosf_cfg_sc_fifo #(.WIDTH(144), .DEPTH(16), .SHOWAHEAD(1)) dut (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(data),
    .wrreq(wrreq), .rdreq(rdreq), .clr_err(clr_err), .q(q),
    .rdempty(rdempty), .wrfull(wrfull),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .usedw(usedw), .overflow(overflow), .underflow(underflow)
`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
    , .parity_err(parity_err)
`endif
  );

  iosf_cfg_sc_fifo #(.WIDTH(8), .DEPTH(4), .SHOWAHEAD(0)) dut0 (
    .clk(clk), .aclr(aclr), .sclr(sclr), .data(d0),
    .wrreq(wr0), .rdreq(rd0), .clr_err(clr0), .q(q0),
    .rdempty(rdempty0), .wrfull(wrfull0),
    .almost_full(afull0), .almost_empty(aempty0),
    .usedw(usedw0), .overflow(ovf0), .underflow(unf0)
`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
    , .parity_err(parity_err0)
`endif
  );

  task automatic chk(input string tag, input logic [143:0] obs,
                     input logic [143:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, " q"}, q, 144'h0);
    chk({tag, " usedw"}, 144'(usedw), 144'd0);
    chk({tag, " rdempty"}, 144'(rdempty), 144'd1);
    chk({tag, " wrfull"}, 144'(wrfull), 144'd0);
    chk({tag, " afull"}, 144'(almost_full), 144'd0);
    chk({tag, " aempty"}, 144'(almost_empty), 144'd1);
    chk({tag, " ovf"}, 144'(overflow), 144'd0);
    chk({tag, " unf"}, 144'(underflow), 144'd0);
  endtask

  // One clock of stimulus against the queue model; flags use the
  // thresholds 14 (almost_full) and 1 (almost_empty).
  task automatic cyc(input logic w, input logic r,
                     input logic [143:0] d);
    bit wa, ra;
    if (cnt > 0) chk("head", q, sb[0]);
    wa = w && (cnt < 16);
    ra = r && (cnt > 0);
    wrreq = w;
    rdreq = r;
    data  = d;
    tick;
    wrreq = 1'b0;
    rdreq = 1'b0;
    if (ra) void'(sb.pop_front());
    if (wa) sb.push_back(d);
    cnt = cnt + int'(wa) - int'(ra);
    chk("usedw", 144'(usedw), 144'(cnt));
    chk("rdempty", 144'(rdempty), 144'(cnt == 0));
    chk("wrfull", 144'(wrfull), 144'(cnt == 16));
    chk("afull", 144'(almost_full), 144'(cnt >= 14));
    chk("aempty", 144'(almost_empty), 144'(cnt <= 1));
  endtask

  initial begin
    aclr = 1'b1; sclr = 1'b0; wrreq = 1'b0; rdreq = 1'b0;
    clr_err = 1'b0; data = '0;
    wr0 = 1'b0; rd0 = 1'b0; clr0 = 1'b0; d0 = '0;
    #12;
    chk_reset("por");
    aclr = 1'b0;
    tick;

    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 144'(i));
    chk("fill q", q, 144'h1);
    cyc(1'b1, 1'b0, 144'h99);
    chk("ovf set", 144'(overflow), 144'd1);
    cyc(1'b0, 1'b0, '0);
    chk("ovf sticky", 144'(overflow), 144'd1);
    for (int i = 1; i <= 16; i++) begin
      chk("drain order", q, 144'(i));
      cyc(1'b0, 1'b1, '0);
    end
    cyc(1'b0, 1'b1, '0);
    chk("unf set", 144'(underflow), 144'd1);
    clr_err = 1'b1;
    cyc(1'b0, 1'b0, '0);
    clr_err = 1'b0;
    chk("clr ovf", 144'(overflow), 144'd0);
    chk("clr unf", 144'(underflow), 144'd0);

    for (int i = 1; i <= 16; i++) cyc(1'b1, 1'b0, 144'h100 + 144'(i));
    clr_err = 1'b1;
    cyc(1'b1, 1'b0, 144'hBAD);
    clr_err = 1'b0;
    chk("set wins", 144'(overflow), 144'd1);
    clr_err = 1'b1;
    cyc(1'b0, 1'b0, '0);
    clr_err = 1'b0;
    chk("ovf cleared", 144'(overflow), 144'd0);
    cyc(1'b1, 1'b1, 144'hCCC);
    chk("full rw usedw", 144'(usedw), 144'd15);
    chk("full rw ovf", 144'(overflow), 144'd1);
    chk("full rw head", q, 144'h102);

    sclr = 1'b1;
    tick;
    sclr = 1'b0;
    chk_reset("sclr1");
    sb.delete();
    cnt = 0;

    for (int i = 0; i < 8; i++) cyc(1'b1, 1'b0, 144'h200 + 144'(i));
    for (int k = 0; k < 100; k++) cyc(1'b1, 1'b1, 144'h300 + 144'(k));
    chk("rw hold usedw", 144'(usedw), 144'd8);
    chk("rw order", q, 144'h35C);

    for (int k = 0; k < 40; k++) begin
      logic w, r;
      w = 1'($urandom_range(0, 1));
      r = 1'($urandom_range(0, 1));
      if (cnt <= 3) r = 1'b0;
      if (cnt >= 13) w = 1'b0;
      cyc(w, r, {$urandom, $urandom, $urandom});
    end

    while (cnt < 9) cyc(1'b1, 1'b0, 144'h400 + 144'(cnt));
    while (cnt > 9) cyc(1'b0, 1'b1, '0);
    chk("pre aclr usedw", 144'(usedw), 144'd9);
    #2;
    aclr = 1'b1;
    #1;
    chk_reset("aclr");
    aclr = 1'b0;
    sb.delete();
    cnt = 0;
    tick;

    cyc(1'b1, 1'b0, 144'hA5);
    chk("sa1 q", q, 144'hA5);
    chk("sa1 empty", 144'(rdempty), 144'd0);
    cyc(1'b1, 1'b0, 144'hB6);
    cyc(1'b0, 1'b1, '0);
    chk("sa1 next", q, 144'hB6);
    sclr = 1'b1;
    tick;
    sclr = 1'b0;
    chk_reset("sclr2");
    sb.delete();
    cnt = 0;

    wr0 = 1'b1; d0 = 8'hA5;
    tick;
    wr0 = 1'b0;
    chk("sa0 empty", 144'(rdempty0), 144'd0);
    chk("sa0 q idle", 144'(q0), 144'd0);
    rd0 = 1'b1;
    tick;
    rd0 = 1'b0;
    chk("sa0 q pop", 144'(q0), 144'hA5);
    chk("sa0 empty2", 144'(rdempty0), 144'd1);
    tick;
    chk("sa0 q hold", 144'(q0), 144'hA5);

`ifdef IOSF_CFG_SC_FIFO_PARITY_EN
    force dut.wr_par = ~(^data);
    data = 144'h5A; wrreq = 1'b1;
    tick;
    wrreq = 1'b0;
    release dut.wr_par;
    chk("par q", q, 144'h5A);
    chk("par err", 144'(parity_err), 144'd1);
    tick;
    chk("par pulse", 144'(parity_err), 144'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
